// File: rtl/imem_fetch_arbiter_pkg.sv
// Shared types and constants for the instruction-memory fetch arbiter.
// Fallback widths apply when the surrounding build does not define them.
`ifndef INSTMEM_ADDR_WIDTH
`define INSTMEM_ADDR_WIDTH 8
`endif
`ifndef INST_LENGTH
`define INST_LENGTH 32
`endif

package imem_fetch_arbiter_pkg;

  localparam int IMEM_ADDR_W     = `INSTMEM_ADDR_WIDTH;
  localparam int IMEM_INST_W     = `INST_LENGTH;
  localparam int MEM_LAT_DEFAULT = 1;

  // Ids are sized for the largest supported requester count.
  localparam int MAX_REQ = 8;
  localparam int ID_W    = $clog2(MAX_REQ);
  localparam int STAT_W  = 16;

  typedef logic [ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } fetch_tag_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/imem_fetch_arbiter_rr_arbiter.sv
// Rotating-priority pick: scans upward from rr_ptr (wrapping) and returns
// the first asserted request as a one-hot grant plus its index.
module imem_fetch_arbiter_rr_arbiter
  import imem_fetch_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  req_id_t            rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output req_id_t            win_id,
  output logic               win_any
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  always_comb begin
    int               idx;
    logic [IDX_W-1:0] sel;
    gnt     = '0;
    win_id  = '0;
    win_any = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = IDX_W'(idx);
      if (!win_any && req[sel]) begin
        win_any  = 1'b1;
        win_id   = req_id_t'(idx);
        gnt[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Shares one InstructionMemory read port among NUM_REQ fetch requesters with
// round-robin grants and an in-order tag pipeline. Optional: IFETCH_ARB_STATS_EN.
module imem_fetch_arbiter
  import imem_fetch_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = IMEM_ADDR_W,
  parameter int INST_W  = IMEM_INST_W,
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [INST_W-1:0]         rsp_inst,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [INST_W-1:0]         mem_inst
`ifdef IFETCH_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] stat_grants,
  output logic [NUM_REQ*STAT_W-1:0] stat_stalls
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  req_id_t            rr_ptr;
  logic [NUM_REQ-1:0] pick;
  req_id_t            win_id;
  logic               win_any;
  logic               grant;
  fetch_tag_t         tag_p [MEM_LAT];
  fetch_tag_t         tag_out;

  imem_fetch_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .gnt     (pick),
    .win_id  (win_id),
    .win_any (win_any)
  );

  // Nothing is granted while reset is held, so no fetch enters the pipeline.
  assign grant = win_any & ~reset;
  assign gnt   = reset ? '0 : pick;

  always_comb begin
    mem_addr = '0;
    if (grant) mem_addr = req_addr[int'(win_id)*ADDR_W +: ADDR_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (int'(win_id) == NUM_REQ - 1) ? '0 : win_id + req_id_t'(1);
    end
  end

  // Stage 0..MEM_LAT-1: tag of each issued fetch travels alongside the memory read
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < MEM_LAT; s++) tag_p[s].valid <= 1'b0;
    end else begin
      tag_p[0] <= '{valid: grant, id: win_id};
      for (int s = 1; s < MEM_LAT; s++) tag_p[s] <= tag_p[s-1];
    end
  end

  // Output stage: route the returning word to the requester that issued it
  assign tag_out = tag_p[MEM_LAT-1];

  always_comb begin
    rsp_valid = '0;
    rsp_inst  = '0;
    if (tag_out.valid && !reset) begin
      rsp_valid[IDX_W'(tag_out.id)] = 1'b1;
      rsp_inst                      = mem_inst;
    end
  end

`ifdef IFETCH_ARB_STATS_EN
  logic [STAT_W-1:0] grant_cnt [NUM_REQ];
  logic [STAT_W-1:0] stall_cnt [NUM_REQ];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reset) begin
        grant_cnt[i] <= '0;
        stall_cnt[i] <= '0;
      end else begin
        if (gnt[i])            grant_cnt[i] <= sat_inc(grant_cnt[i]);
        if (req[i] && !gnt[i]) stall_cnt[i] <= sat_inc(stall_cnt[i]);
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_grants[g*STAT_W +: STAT_W] = grant_cnt[g];
    assign stat_stalls[g*STAT_W +: STAT_W] = stall_cnt[g];
  end
`endif

endmodule
